// File: rtl/scanline_packet_tx.sv
// Pops one scanline and sends it as a UART 8N1 packet: SYNC, line tag, payload bytes[, checksum when SCANLINE_CHECKSUM_EN].
// Latency: first start bit in the cycle after fifo_empty=0 is seen in IDLE; each byte takes 10*BAUD_DIV cycles.
// Backpressure: one fifo_ack per packet; fifo_empty/scanline are ignored until the packet ends plus one idle cycle.
module scanline_packet_tx #(
    parameter int          LINE_BITS = 160,
    parameter int          BAUD_DIV  = 1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 CLK12M,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [LINE_BITS-1:0] scanline,
    output logic                 fifo_ack,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int NB = LINE_BITS / 8;
`ifdef SCANLINE_CHECKSUM_EN
    localparam int PKT_BYTES = NB + 3;
`else
    localparam int PKT_BYTES = NB + 2;
`endif
    localparam int BIW = $clog2(NB + 3);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(PKT_BYTES - 1);
    localparam logic [BIW-1:0] PAY_LAST = BIW'(NB + 1);
    localparam logic [7:0]     TMR_LAST = 8'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           bit_tmr;
    logic [2:0]           bit_idx;
    logic [BIW-1:0]       byte_idx;
    logic [LINE_BITS-1:0] shadow;
    logic [7:0]           line_tag;
    logic [7:0]           cur_byte;
    logic                 bit_end;
    logic                 last_byte;
    logic                 in_payload;
    logic                 uart_tx_nxt;
    logic                 fifo_ack_nxt;
    logic                 busy_nxt;
`ifdef SCANLINE_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign bit_end    = (bit_tmr == TMR_LAST);
    assign last_byte  = (byte_idx == LAST_IDX);
    assign in_payload = (byte_idx >= BIW'(2)) && (byte_idx <= PAY_LAST);

    // Payload is shifted out of the shadow, so the current payload byte is always its low byte.
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_idx == BIW'(1))
            cur_byte = line_tag;
        else if (in_payload)
            cur_byte = shadow[7:0];
`ifdef SCANLINE_CHECKSUM_EN
        else if (byte_idx == LAST_IDX)
            cur_byte = csum;
`endif
    end

    always_ff @(posedge CLK12M) begin
        if (!reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            fifo_ack <= 1'b0;
            busy     <= 1'b0;
            line_tag <= 8'h00;
            bit_tmr  <= 8'h00;
            bit_idx  <= 3'd0;
            byte_idx <= '0;
            shadow   <= '0;
`ifdef SCANLINE_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            state    <= state_nxt;
            uart_tx  <= uart_tx_nxt;
            fifo_ack <= fifo_ack_nxt;
            busy     <= busy_nxt;
            bit_tmr  <= (state == IDLE || bit_end) ? 8'h00 : bit_tmr + 8'd1;
            if (state == IDLE) begin
                bit_idx  <= 3'd0;
                byte_idx <= '0;
                if (!fifo_empty)
                    shadow <= scanline;
`ifdef SCANLINE_CHECKSUM_EN
                csum <= 8'h00;
`endif
            end else if (bit_end) begin
                if (state == DATA)
                    bit_idx <= bit_idx + 3'd1;
                if (state == STOP) begin
                    if (in_payload)
                        shadow <= shadow >> 8;
`ifdef SCANLINE_CHECKSUM_EN
                    if (byte_idx != '0 && byte_idx <= PAY_LAST)
                        csum <= csum ^ cur_byte;
`endif
                    if (last_byte)
                        line_tag <= line_tag + 8'd1;
                    else
                        byte_idx <= byte_idx + BIW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = START;
            START: if (bit_end) state_nxt = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end) state_nxt = last_byte ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the start bit is launched together with fifo_ack.
    always_comb begin
        uart_tx_nxt  = uart_tx;
        fifo_ack_nxt = 1'b0;
        busy_nxt     = busy;
        case (state)
            IDLE: begin
                uart_tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    uart_tx_nxt  = 1'b0;
                    fifo_ack_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            START: if (bit_end) uart_tx_nxt = cur_byte[0];
            DATA:  if (bit_end) uart_tx_nxt = (bit_idx == 3'd7) ? 1'b1 : cur_byte[bit_idx + 3'd1];
            STOP: begin
                if (bit_end) begin
                    uart_tx_nxt = last_byte;
                    if (last_byte)
                        busy_nxt = 1'b0;
                end
            end
            default: uart_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_scanline_packet_tx.sv
// Bench for scanline_packet_tx: FIFO model + UART byte decoder against a byte scoreboard, plus cycle-exact sequences.
module tb_scanline_packet_tx;
    localparam int LINE_BITS = 160;
    localparam int NB        = LINE_BITS / 8;
`ifdef SCANLINE_CHECKSUM_EN
    localparam int PKT = NB + 3;
`else
    localparam int PKT = NB + 2;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 fifo_empty;
    logic [LINE_BITS-1:0] scanline;
    logic                 fifo_ack, uart_tx, busy;
    logic                 fifo_empty4;
    logic [LINE_BITS-1:0] scanline4;
    logic                 fifo_ack4, uart_tx4, busy4;

    scanline_packet_tx #(.LINE_BITS(LINE_BITS), .BAUD_DIV(1), .SYNC_BYTE(SYNC)) u_dut (
        .CLK12M(clk), .reset(reset), .fifo_empty(fifo_empty), .scanline(scanline),
        .fifo_ack(fifo_ack), .uart_tx(uart_tx), .busy(busy));

    scanline_packet_tx #(.LINE_BITS(LINE_BITS), .BAUD_DIV(4), .SYNC_BYTE(SYNC)) u_dut4 (
        .CLK12M(clk), .reset(reset), .fifo_empty(fifo_empty4), .scanline(scanline4),
        .fifo_ack(fifo_ack4), .uart_tx(uart_tx4), .busy(busy4));

    typedef struct {
        logic [LINE_BITS-1:0] line;
        logic [7:0]           tag;
        logic [7:0]           csum;
    } vec_t;
    vec_t tbl[5];

    logic [LINE_BITS-1:0] fifo_q[$];
    logic [7:0]           exp_q[$];
    int                   ack_times[$];
    int  n_checks = 0, n_fail = 0;
    int  ack_cnt = 0, cyc = 0, pop_while_busy = 0, idle_bad = 0;
    logic prev_busy = 1'b0, prev_tx = 1'b1;
    bit  mon_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xor_csum(input logic [LINE_BITS-1:0] line, input logic [7:0] tag);
        logic [7:0] r = tag;
        for (int k = 0; k < NB; k++) r ^= line[8*k +: 8];
        return r;
    endfunction

    task automatic push_line(input logic [LINE_BITS-1:0] line, input logic [7:0] tag, input logic [7:0] csum);
        fifo_q.push_back(line);
        exp_q.push_back(SYNC);
        exp_q.push_back(tag);
        for (int k = 0; k < NB; k++) exp_q.push_back(line[8*k +: 8]);
`ifdef SCANLINE_CHECKSUM_EN
        exp_q.push_back(csum);
`else
        if (csum === 8'hxx) $display("note: unknown checksum for tag %0h", tag);
`endif
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n = 0;
        while (fifo_ack !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(fifo_ack === 1'b1), 64'd1);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n = 0;
        while ((ack_cnt < target || busy !== 1'b0 || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
    endtask

    // Show-ahead FIFO model: head visible while non-empty, popped by fifo_ack.
    initial begin
        fifo_empty = 1'b1;
        scanline   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fifo_ack === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_empty = (fifo_q.size() == 0);
            scanline   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_ack === 1'b1) begin
                ack_cnt++;
                ack_times.push_back(cyc);
                if (prev_busy === 1'b1) pop_while_busy++;
                if (prev_tx !== 1'b1) idle_bad++;
            end
            prev_busy = busy;
            prev_tx   = uart_tx;
        end
    end

    // UART decoder for the BAUD_DIV=1 instance; every received byte is checked against the scoreboard.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    b[i] = uart_tx;
                end
                @(negedge clk);
                stop_bit = uart_tx;
                if (mon_en) begin
                    if (exp_q.size() == 0)
                        check("rx_unexpected_byte", 64'(b), 64'h100);
                    else
                        check("rx_byte", 64'(b), 64'(exp_q.pop_front()));
                    check("rx_stop_bit", 64'(stop_bit), 64'd1);
                end
            end
        end
    end

    initial begin
        int a0, t0, n, extra;
        logic [39:0] wave, wexp;
        logic [7:0]  sb;
        logic [LINE_BITS-1:0] rl;

        tbl[0] = '{160'h0100_00FF, 8'h00, 8'hFE};
        tbl[1] = '{160'h0, 8'h01, 8'h01};
        tbl[2] = '{{LINE_BITS{1'b1}}, 8'h02, 8'h02};
        tbl[3] = '{160'h0100_00FF, 8'h03, 8'hFD};
        tbl[4] = '{160'h11223344_55667788_99AABBCC_DDEEFF00_12345678, 8'h04, 8'h0C};

        reset       = 1'b0;
        fifo_empty4 = 1'b1;
        scanline4   = '0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        check("reset_fifo_ack", 64'(fifo_ack), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single packet: ack coincides with start bit, busy for exactly PKT*10 cycles.
        a0 = ack_cnt;
        push_line(tbl[0].line, tbl[0].tag, tbl[0].csum);
        wait_ack("t1_ack_seen", 20);
        check("t1_start_with_ack", 64'(uart_tx), 64'd0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_cycles", 64'(n), 64'(PKT * 10));
        check("t1_idle_tx", 64'(uart_tx), 64'd1);
        check("t1_ack_count", 64'(ack_cnt - a0), 64'd1);

        // Back-to-back lines: one idle cycle between packets, one pop each.
        a0 = ack_cnt;
        t0 = ack_times.size();
        for (int i = 1; i < 4; i++) push_line(tbl[i].line, tbl[i].tag, tbl[i].csum);
        wait_done("t3_done", a0 + 3, 3000);
        repeat (5) @(negedge clk);
        check("t3_ack_count", 64'(ack_cnt - a0), 64'd3);
        if (ack_times.size() >= t0 + 3) begin
            for (int g = 1; g < 3; g++)
                check("t3_packet_gap", 64'(ack_times[t0+g] - ack_times[t0+g-1]), 64'(PKT * 10 + 1));
        end else
            check("t3_acks_logged", 64'(ack_times.size()), 64'(t0 + 3));

        a0 = ack_cnt;
        push_line(tbl[4].line, tbl[4].tag, tbl[4].csum);
        wait_done("t4_done", a0 + 1, 1000);

        // BAUD_DIV=4 instance: first byte waveform, then total packet length.
        scanline4   = tbl[0].line;
        fifo_empty4 = 1'b0;
        n = 0;
        while (fifo_ack4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b4_ack_seen", 64'(fifo_ack4 === 1'b1), 64'd1);
        fifo_empty4 = 1'b1;
        sb = SYNC;
        for (int b = 0; b < 10; b++)
            for (int r = 0; r < 4; r++)
                wexp[4*b+r] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sb[b-1];
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            wave[c] = uart_tx4;
            if (c > 0 && fifo_ack4 === 1'b1) extra++;
            @(negedge clk);
        end
        check("b4_first_byte_wave", 64'(wave), 64'(wexp));
        check("b4_second_start", 64'(uart_tx4), 64'd0);
        n = 40;
        while (busy4 === 1'b1 && n < 2000) begin
            if (fifo_ack4 === 1'b1) extra++;
            n++;
            @(negedge clk);
        end
        check("b4_busy_cycles", 64'(n), 64'(PKT * 40));
        check("b4_extra_acks", 64'(extra), 64'd0);

        // Reset at byte 7, data bit 3: packet abandoned, tag restarts at 00.
        rl = {5{$urandom()}};
        push_line(rl, 8'h05, xor_csum(rl, 8'h05));
        wait_ack("rst_ack_seen", 20);
        repeat (74) @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fifo_ack", 64'(fifo_ack), 64'd0);
        a0 = ack_cnt;
        repeat (12) @(negedge clk);
        check("rst_no_ack", 64'(ack_cnt - a0), 64'd0);
        exp_q.delete();
        mon_en = 1'b1;
        rl = {5{$urandom()}};
        push_line(rl, 8'h00, xor_csum(rl, 8'h00));
        wait_done("rst_next_done", a0 + 1, 1000);

        // 257 packets from a fresh reset: tags 00..FF then wrap to 00.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        a0 = ack_cnt;
        for (int i = 0; i < 257; i++) begin
            rl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            push_line(rl, 8'(i), xor_csum(rl, 8'(i)));
        end
        wait_done("wrap_done", a0 + 257, 60000);
        repeat (12) @(negedge clk);
        check("wrap_ack_count", 64'(ack_cnt - a0), 64'd257);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            if (uart_tx !== 1'b1 || fifo_ack !== 1'b0) extra++;
            @(negedge clk);
        end
        check("idle_quiet", 64'(extra), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("no_pop_while_busy", 64'(pop_while_busy), 64'd0);
        check("idle_before_start", 64'(idle_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
